// File: rtl/fetch_bundle_queue.sv
// Four-lane fetch bundle FIFO (first-word-fall-through): one-cycle push-to-head latency, stall_o raised while full.
// Optional same-cycle empty-queue bypass under macro FETCH_QUEUE_BYPASS_EN.
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 2
`endif

module fetch_bundle_queue #(
   parameter int DEPTH = 4,
   parameter int PKT_W = `SIZE_INSTRUCTION + 2*`SIZE_PC + `SIZE_CTI_LOG + 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush_i,
   input  logic                     fs2Ready_i,
   input  logic                     inst0Valid_i,
   input  logic                     inst1Valid_i,
   input  logic                     inst2Valid_i,
   input  logic                     inst3Valid_i,
   input  logic [PKT_W-1:0]         inst0Packet_i,
   input  logic [PKT_W-1:0]         inst1Packet_i,
   input  logic [PKT_W-1:0]         inst2Packet_i,
   input  logic [PKT_W-1:0]         inst3Packet_i,
   output logic                     stall_o,
   input  logic                     decodeStall_i,
   output logic                     bundleValid_o,
   output logic                     inst0Valid_o,
   output logic                     inst1Valid_o,
   output logic                     inst2Valid_o,
   output logic                     inst3Valid_o,
   output logic [PKT_W-1:0]         inst0Packet_o,
   output logic [PKT_W-1:0]         inst1Packet_o,
   output logic [PKT_W-1:0]         inst2Packet_o,
   output logic [PKT_W-1:0]         inst3Packet_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [3:0]       vld_mem [DEPTH];
   logic [PKT_W-1:0] pkt_mem [DEPTH][4];

   logic [3:0]       in_vld;
   logic [PKT_W-1:0] in_pkt [4];
   logic [3:0]       out_vld;
   logic [PKT_W-1:0] out_pkt [4];

   logic empty;
   logic pushable;
   logic bypass;
   logic push;
   logic pop;

   assign in_vld    = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
   assign in_pkt[0] = inst0Packet_i;
   assign in_pkt[1] = inst1Packet_i;
   assign in_pkt[2] = inst2Packet_i;
   assign in_pkt[3] = inst3Packet_i;

   assign empty    = (count == '0);
   assign stall_o  = (count == FULL_CNT);
   assign pushable = fs2Ready_i && (|in_vld) && !stall_o && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue and a consumer ready: hand the bundle straight through, never stored.
   assign bypass = reset_n && empty && pushable && !decodeStall_i;
`else
   assign bypass = 1'b0;
`endif

   assign push = pushable && !bypass;
   assign pop  = !empty && !decodeStall_i && !flush_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            vld_mem[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            vld_mem[wr_ptr] <= in_vld;
            wr_ptr          <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Packet payload is never reset; the empty check below keeps stale data off the outputs.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int n = 0; n < 4; n++) begin
            pkt_mem[wr_ptr][n] <= in_pkt[n];
         end
      end
   end

   always_comb begin
      out_vld = '0;
      for (int n = 0; n < 4; n++) begin
         out_pkt[n] = '0;
      end
      if (!empty) begin
         out_vld = vld_mem[rd_ptr];
         for (int n = 0; n < 4; n++) begin
            out_pkt[n] = pkt_mem[rd_ptr][n];
         end
      end else if (bypass) begin
         out_vld = in_vld;
         for (int n = 0; n < 4; n++) begin
            out_pkt[n] = in_pkt[n];
         end
      end
   end

   assign bundleValid_o = !empty || bypass;
   assign count_o       = count;
   assign inst0Valid_o  = out_vld[0];
   assign inst1Valid_o  = out_vld[1];
   assign inst2Valid_o  = out_vld[2];
   assign inst3Valid_o  = out_vld[3];
   assign inst0Packet_o = out_pkt[0];
   assign inst1Packet_o = out_pkt[1];
   assign inst2Packet_o = out_pkt[2];
   assign inst3Packet_o = out_pkt[3];

endmodule

// File: doc/fetch_bundle_queue.md
FETCH_BUNDLE_QUEUE -- requirements
Module: fetch_bundle_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of 4-wide bundle entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter PKT_W, default `SIZE_INSTRUCTION+2*`SIZE_PC+`SIZE_CTI_LOG+1, packet width per lane.
REQ-003 clk  in  1  sole clock; all state changes on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 flush_i  in  1  synchronous flush from recovery.
REQ-006 fs2Ready_i  in  1  incoming bundle present, from Fetch2Decode fs2Ready_o.
REQ-007 instNValid_i (N=0..3)  in  1 each  lane valid.
REQ-008 instNPacket_i (N=0..3)  in  PKT_W each  lane packet.
REQ-009 stall_o  out  1  back-pressure to the fetch/decode pipeline register stall_i.
REQ-010 decodeStall_i  in  1  downstream cannot consume this cycle.
REQ-011 bundleValid_o  out  1  head bundle presented.
REQ-012 instNValid_o / instNPacket_o (N=0..3)  out  1 / PKT_W  head bundle lanes.
REQ-013 count_o  out  log2(DEPTH)+1  occupied entries.

Function
REQ-014 Queue SHALL be first-word-fall-through: head entry driven combinationally from storage at read pointer.
REQ-015 Push SHALL occur when fs2Ready_i=1, any instNValid_i=1, stall_o=0 and flush_i=0; bundle written whole at write pointer.
REQ-016 Bundle with fs2Ready_i=1 and all four lane valids 0 SHALL be discarded without push.
REQ-017 stall_o SHALL equal (count_o==DEPTH), combinational from registered count; push never occurs while full.
REQ-018 Pop SHALL occur when bundleValid_o=1, decodeStall_i=0 and flush_i=0.
REQ-019 bundleValid_o SHALL equal (count_o!=0) without bypass.
REQ-020 When count_o==0, all instNValid_o and instNPacket_o SHALL be driven 0.
REQ-021 Simultaneous push and pop SHALL leave count_o unchanged; both pointers advance.
REQ-022 Full with simultaneous pop: stall_o stays 1 that cycle, no push; stall_o drops next cycle.
REQ-023 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count_o saturates at neither bound (push blocked when full, pop blocked when empty).
REQ-024 flush_i=1 SHALL at next edge zero pointers and count_o, discarding same-cycle push and pop; flush has priority over all.
REQ-025 Lane order SHALL be preserved: lane N in equals lane N out; no compaction.
REQ-026 Minimum latency push to bundleValid_o SHALL be one cycle without bypass.

Reset
REQ-027 reset_n=0 SHALL asynchronously clear pointers, count_o and all stored lane valid bits; stall_o=0, bundleValid_o=0, all outputs 0 while asserted.
REQ-028 Stored packet data need not be reset; it SHALL never reach outputs while empty.
REQ-029 Reset asserted mid-operation SHALL discard all entries; first push after release SHALL be accepted on the first edge with reset_n=1.

Configuration
REQ-030 Macro FETCH_QUEUE_BYPASS_EN defined: when count_o==0, a pushable bundle and decodeStall_i=0 and flush_i=0, the input bundle SHALL appear on outputs with bundleValid_o=1 in the same cycle and SHALL NOT be written; count_o stays 0.
REQ-031 With FETCH_QUEUE_BYPASS_EN defined and decodeStall_i=1 while empty, the bundle SHALL be pushed normally.
REQ-032 Macro undefined: no combinational path from any input lane to any output; REQ-026 latency holds.

Verification
REQ-033 Reset release, push lanes valid 1111 with packets A,B,C,D -> next cycle bundleValid_o=1, packets A,B,C,D, count_o=1.
REQ-034 decodeStall_i=1, push 4 bundles (DEPTH=4) -> count_o=4, stall_o=1; 5th bundle held upstream, not written; release stall -> bundles popped in order, one per cycle.
REQ-035 Full queue, decodeStall_i=0, fs2Ready_i=1 -> cycle 1: pop, no push, count_o=3; cycle 2: stall_o=0, push accepted, count_o=3.
REQ-036 Count 2, flush_i=1 with concurrent push -> next cycle count_o=0, bundleValid_o=0, outputs 0.
REQ-037 Push bundle with lane valids 0000, fs2Ready_i=1 -> count_o unchanged; lane valids 0101 -> instNValid_o=0101 out.
REQ-038 FETCH_QUEUE_BYPASS_EN defined, empty, push packet E, decodeStall_i=0 -> same cycle bundleValid_o=1, inst0Packet_o=E, count_o stays 0.
